// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus bundle: inst SRAM request/response and the IF->ID valid/allowin handshake.
// The master side is the fetch queue; the slave side is the SRAM plus the decode stage.
interface if_fetch_queue_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;

  modport master (
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata,
    input  ds_allowin,
    output fs_to_ds_valid, fs_pc, fs_inst
  );

  modport slave (
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata,
    output ds_allowin,
    input  fs_to_ds_valid, fs_pc, fs_inst
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: sequential PC generation into a 1-cycle synchronous inst SRAM,
// a DEPTH-entry instruction queue toward ID, and PC redirect with queue/in-flight flush.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  if_fetch_queue_if.master fq,
  output logic [CNT_W-1:0] fq_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             pend;
  logic [31:0]      pend_pc;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];

  logic [CNT_W-1:0] credit_used;
  logic             issue;
  logic             push;
  logic             pop;
  logic             head_valid;

  // Credit counts the in-flight response as occupied, and deliberately ignores a
  // same-cycle pop, so a returning word always has a free slot waiting for it.
  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    credit_used = '0;
    issue       = 1'b0;
    push        = 1'b0;
    head_valid  = 1'b0;
    pop         = 1'b0;

    credit_used = count + {{(CNT_W-1){1'b0}}, pend};
    issue       = resetn & ~redirect_valid & (credit_used < CNT_W'(DEPTH));
    push        = resetn & pend & ~redirect_valid;
    head_valid  = resetn & ~redirect_valid & (count != '0);
    pop         = head_valid & fq.ds_allowin;
  end

  assign fq.inst_sram_en    = issue;
  assign fq.inst_sram_wen   = 4'b0000;
  assign fq.inst_sram_addr  = fetch_pc;
  assign fq.inst_sram_wdata = 32'h0000_0000;

  // Head is taken straight from storage; rdata never bypasses to the outputs.
  assign fq.fs_to_ds_valid  = head_valid;
  assign fq.fs_pc           = pc_mem[rd_ptr];
  assign fq.fs_inst         = inst_mem[rd_ptr];
  assign fq_count           = count;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      pend     <= 1'b0;
      pend_pc  <= '0;
      // NOTE: the queue storage is cleared on reset so an empty head reads as zero.
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Flush everything; the response arriving this cycle belongs to the old stream.
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      pend     <= 1'b0;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      pend    <= issue;
      pend_pc <= fetch_pc;

      if (push) begin
        pc_mem[wr_ptr]   <= pend_pc;
        inst_mem[wr_ptr] <= fq.inst_sram_rdata;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios plus randomized traffic,
// all compared against a queue-based behavioural model of the fetch stage.
module tb_if_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam int          DEPTH    = 4;
  localparam int          CNT_W    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             resetn;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] fq_count;

  if_fetch_queue_if bus ();

  if_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fq             (bus),
    .fq_count       (fq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Synchronous SRAM: data one cycle after en, garbage otherwise.
  always @(posedge clk) begin
    if (bus.inst_sram_en) bus.inst_sram_rdata <= mem_word(bus.inst_sram_addr);
    else                  bus.inst_sram_rdata <= $urandom;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h expected=%08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: the queue of delivered {pc, inst}, one in-flight fetch, the next PC.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      mq[$];
  logic        m_inflight;
  logic [31:0] m_inflight_pc;
  logic [31:0] m_next_pc;

  // One clock cycle: drive inputs after the falling edge, check, then advance the model
  // to what the following rising edge should produce.
  task automatic step(input logic rn, input logic rv, input logic [31:0] rp, input logic al);
    logic exp_en;
    logic exp_valid;
    @(negedge clk);
    resetn         = rn;
    redirect_valid = rv;
    redirect_pc    = rp;
    bus.ds_allowin = al;
    #1;
    check("wen", {28'd0, bus.inst_sram_wen}, 32'd0);
    check("wdata", bus.inst_sram_wdata, 32'd0);
    if (!rn) begin
      check("en_in_reset", {31'd0, bus.inst_sram_en}, 32'd0);
      check("valid_in_reset", {31'd0, bus.fs_to_ds_valid}, 32'd0);
      mq.delete();
      m_inflight = 1'b0;
      m_next_pc  = RESET_PC;
    end else if (rv) begin
      check("en_in_redirect", {31'd0, bus.inst_sram_en}, 32'd0);
      check("valid_in_redirect", {31'd0, bus.fs_to_ds_valid}, 32'd0);
      check("count", 32'(fq_count), 32'(mq.size()));
      mq.delete();
      m_inflight = 1'b0;
      m_next_pc  = rp & 32'hFFFF_FFFC;
    end else begin
      exp_en    = (mq.size() + int'(m_inflight)) < DEPTH;
      exp_valid = mq.size() > 0;
      check("en", {31'd0, bus.inst_sram_en}, {31'd0, exp_en});
      if (exp_en) check("addr", bus.inst_sram_addr, m_next_pc);
      check("valid", {31'd0, bus.fs_to_ds_valid}, {31'd0, exp_valid});
      check("count", 32'(fq_count), 32'(mq.size()));
      if (exp_valid) begin
        check("fs_pc", bus.fs_pc, mq[0].pc);
        check("fs_inst", bus.fs_inst, mq[0].inst);
        if (al) void'(mq.pop_front());
      end
      if (m_inflight) mq.push_back('{pc: m_inflight_pc, inst: mem_word(m_inflight_pc)});
      m_inflight    = exp_en;
      m_inflight_pc = m_next_pc;
      if (exp_en) m_next_pc = m_next_pc + 32'd4;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int issues;

  initial begin
    resetn         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    bus.ds_allowin = 1'b1;
    m_inflight     = 1'b0;
    m_inflight_pc  = '0;
    m_next_pc      = RESET_PC;

    // 1: streaming fetch with ID always ready.
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    check("post_reset_fs_pc", bus.fs_pc, 32'd0);
    check("post_reset_fs_inst", bus.fs_inst, 32'd0);
    check("first_addr", bus.inst_sram_addr, RESET_PC);
    step(1'b1, 1'b0, '0, 1'b1);
    check("no_valid_t1", {31'd0, bus.fs_to_ds_valid}, 32'd0);
    step(1'b1, 1'b0, '0, 1'b1);
    check("first_valid_t2", {31'd0, bus.fs_to_ds_valid}, 32'd1);
    check("first_fs_pc", bus.fs_pc, RESET_PC);
    repeat (10) step(1'b1, 1'b0, '0, 1'b1);

    // 2: ID stalled from reset; exactly DEPTH fetches fill the queue.
    step(1'b0, 1'b0, '0, 1'b0);
    issues = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, '0, 1'b0);
      if (bus.inst_sram_en) issues++;
    end
    check("full_issues", 32'(issues), 32'(DEPTH));
    check("full_count", 32'(fq_count), 32'(DEPTH));
    check("full_head", bus.fs_pc, RESET_PC);
    repeat (8) step(1'b1, 1'b0, '0, 1'b1);

    // 3: redirect while a response is in flight.
    step(1'b1, 1'b1, 32'h8000_1000, 1'b1);
    check("redir_valid_low", {31'd0, bus.fs_to_ds_valid}, 32'd0);
    step(1'b1, 1'b0, '0, 1'b1);
    check("redir_addr", bus.inst_sram_addr, 32'h8000_1000);
    repeat (6) step(1'b1, 1'b0, '0, 1'b1);

    // 4: unaligned target, redirect held three cycles.
    repeat (3) step(1'b1, 1'b1, 32'h8000_2003, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    check("aligned_addr", bus.inst_sram_addr, 32'h8000_2000);
    repeat (6) step(1'b1, 1'b0, '0, 1'b1);

    // 5: PC wraps past the top of the address space.
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (8) step(1'b1, 1'b0, '0, 1'b1);

    // 6: reset pulse with a full queue.
    repeat (8) step(1'b1, 1'b0, '0, 1'b0);
    check("pre_reset_full", 32'(fq_count), 32'(DEPTH));
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("rst_count", 32'(fq_count), 32'd0);
    check("rst_valid", {31'd0, bus.fs_to_ds_valid}, 32'd0);
    check("rst_en", {31'd0, bus.inst_sram_en}, 32'd1);
    check("rst_addr", bus.inst_sram_addr, RESET_PC);

    // Randomized traffic: stalls, redirects (some near the wrap point), occasional resets.
    for (int i = 0; i < 2000; i++) begin
      logic        rn;
      logic        rv;
      logic [31:0] rp;
      logic        al;
      rn = ($urandom_range(99) >= 2);
      rv = ($urandom_range(99) < 6);
      rp = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(31))) : $urandom;
      al = ($urandom_range(99) < 65);
      step(rn, rv, rp, al);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
